// File: rtl/ase_pkg.sv
// Shared ASE CCI-P definitions: TX header layout, request types, line length encoding.
package ase_pkg;

  localparam int CCIP_DATA_WIDTH = 512;
  localparam int ASE_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    CCIP_LEN_1       = 2'b00,
    CCIP_LEN_2       = 2'b01,
    CCIP_LEN_ILLEGAL = 2'b10,
    CCIP_LEN_4       = 2'b11
  } ccip_len_t;

  typedef enum logic [3:0] {
    CCIP_WRLINE_I = 4'h0,
    CCIP_WRLINE_M = 4'h1,
    CCIP_WRFENCE  = 4'h4
  } ccip_reqtype_t;

  typedef struct packed {
    logic [1:0]    vc_sel;
    logic          sop;
    ccip_len_t     len;
    ccip_reqtype_t reqtype;
    logic [41:0]   addr;
    logic [15:0]   mdata;
  } TxHdr_t;

endpackage

// File: rtl/ccip_wr_arbiter_pkg.sv
// Local types and helpers for the CCI-P write-channel arbiter.
package ccip_wr_arbiter_pkg;
  import ase_pkg::*;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Beats still owed after the first beat of a packet.
  function automatic logic [1:0] burst_extra(ccip_len_t len);
    case (len)
      CCIP_LEN_2: return 2'd1;
      CCIP_LEN_4: return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ccip_wr_arbiter_if.sv
// Requester-side and channel-side signals of the CCI-P write arbiter.
interface ccip_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = $bits(ase_pkg::TxHdr_t),
  parameter int DATA_W  = ase_pkg::CCIP_DATA_WIDTH
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*HDR_W-1:0]  req_hdr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ch_full;
  logic                      ch_wr_en;
  logic [HDR_W-1:0]          ch_hdr;
  logic [DATA_W-1:0]         ch_data;
  logic [IW-1:0]             grant_id;
  logic                      err_len;
  logic                      err_sop;

  modport slave (
    input  req_valid, req_hdr, req_data, ch_full,
    output req_ready, ch_wr_en, ch_hdr, ch_data, grant_id, err_len, err_sop
  );

  modport master (
    output req_valid, req_hdr, req_data, ch_full,
    input  req_ready, ch_wr_en, ch_hdr, ch_data, grant_id, err_len, err_sop
  );

endinterface

// File: rtl/ccip_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req after index last, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       vld,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest hit overwrites the others.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/ccip_wr_arbiter.sv
// Round-robin arbiter sharing one CCI-P TX1 write channel among NUM_REQ requesters.
// Optional per-requester statistics when ASE_ARB_STATS_EN is defined.
module ccip_wr_arbiter
  import ase_pkg::*;
  import ccip_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int HDR_W   = $bits(TxHdr_t),
  parameter int DATA_W  = CCIP_DATA_WIDTH
) (
  input logic              clk,
  input logic              rst,
  ccip_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [1:0]         beats_left_q, beats_left_d;
  logic [IW-1:0]      last_grant_q, grant_q;
  logic               err_len_q, err_sop_q;

  logic               pick_vld;
  logic [IW-1:0]      pick_idx, sel_idx_p0;
  TxHdr_t             sel_hdr_p0;
  logic [DATA_W-1:0]  sel_data_p0;
  logic [NUM_REQ-1:0] ready_p0;
  logic               acc_p0, fwd_p0, start_pkt_p0, set_err_len_p0, set_err_sop_p0;

  logic               vld_p1;
  logic [HDR_W-1:0]   hdr_p1;
  logic [DATA_W-1:0]  data_p1;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (bus.req_valid),
    .last (last_grant_q),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  // Stage p0: select the owning requester, decide ready and classify the beat
  always_comb begin
    sel_idx_p0     = (state_q == ARB_BURST) ? grant_q : pick_idx;
    sel_hdr_p0     = TxHdr_t'(bus.req_hdr[sel_idx_p0*HDR_W +: HDR_W]);
    sel_data_p0    = bus.req_data[sel_idx_p0*DATA_W +: DATA_W];
    ready_p0       = '0;
    if (!bus.ch_full) begin
      if (state_q == ARB_BURST) ready_p0[grant_q] = 1'b1;
      else if (pick_vld)        ready_p0[pick_idx] = 1'b1;
    end
    acc_p0         = |(ready_p0 & bus.req_valid);
    fwd_p0         = 1'b0;
    start_pkt_p0   = 1'b0;
    set_err_len_p0 = 1'b0;
    set_err_sop_p0 = 1'b0;
    if (acc_p0) begin
      if (state_q == ARB_BURST) begin
        fwd_p0         = 1'b1;
        set_err_sop_p0 = sel_hdr_p0.sop;
      end else if (!sel_hdr_p0.sop) begin
        fwd_p0         = 1'b1;
        set_err_sop_p0 = 1'b1;
      end else if (sel_hdr_p0.reqtype == CCIP_WRFENCE) begin
        fwd_p0         = 1'b1;
      end else if (sel_hdr_p0.len == CCIP_LEN_ILLEGAL) begin
        set_err_len_p0 = 1'b1;
      end else begin
        fwd_p0         = 1'b1;
        start_pkt_p0   = (sel_hdr_p0.len != CCIP_LEN_1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    case (state_q)
      ARB_IDLE: begin
        if (start_pkt_p0) begin
          state_d      = ARB_BURST;
          beats_left_d = burst_extra(sel_hdr_p0.len);
        end
      end
      ARB_BURST: begin
        if (acc_p0) begin
          beats_left_d = beats_left_q - 2'd1;
          if (beats_left_q == 2'd1) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      beats_left_q <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      err_len_q    <= 1'b0;
      err_sop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      if (acc_p0 && state_q == ARB_IDLE) begin
        grant_q      <= sel_idx_p0;
        last_grant_q <= sel_idx_p0;
      end
      err_len_q <= err_len_q | set_err_len_p0;
      err_sop_q <= err_sop_q | set_err_sop_p0;
    end
  end

  // Stage p1: registered channel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      hdr_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= fwd_p0;
      if (fwd_p0) begin
        hdr_p1  <= HDR_W'(sel_hdr_p0);
        data_p1 <= sel_data_p0;
      end
    end
  end

  assign bus.req_ready = ready_p0;
  assign bus.ch_wr_en  = vld_p1;
  assign bus.ch_hdr    = hdr_p1;
  assign bus.ch_data   = data_p1;
  assign bus.grant_id  = grant_q;
  assign bus.err_len   = err_len_q;
  assign bus.err_sop   = err_sop_q;

`ifdef ASE_ARB_STATS_EN
  logic [31:0] pkt_cnt  [NUM_REQ];
  logic [31:0] beat_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pkt_cnt[i]  <= '0;
        beat_cnt[i] <= '0;
      end
    end else begin
      if (fwd_p0 && state_q == ARB_IDLE) pkt_cnt[sel_idx_p0] <= pkt_cnt[sel_idx_p0] + 32'd1;
      if (fwd_p0) beat_cnt[sel_idx_p0] <= beat_cnt[sel_idx_p0] + 32'd1;
      if (set_err_len_p0)
        $display("ccip_wr_arbiter: illegal len from requester %0d mdata=%0h", sel_idx_p0, sel_hdr_p0.mdata);
      if (set_err_sop_p0)
        $display("ccip_wr_arbiter: sop mismatch from requester %0d mdata=%0h", sel_idx_p0, sel_hdr_p0.mdata);
    end
  end
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_ccip_wr_arbiter.sv
// Self-checking bench for ccip_wr_arbiter: vector table, hand sequences, randomized packet-level model.
module tb_ccip_wr_arbiter;
  import ase_pkg::*;

  localparam int N  = 4;
  localparam int HW = $bits(TxHdr_t);
  localparam int DW = CCIP_DATA_WIDTH;

  typedef struct {
    int            id;
    ccip_reqtype_t t;
    logic [1:0]    len;
    logic          sop;
    logic [41:0]   addr;
    bit            e_wr;
    bit            e_len;
    bit            e_sop;
    bit            e_idle;
  } vec_t;

  typedef struct {
    TxHdr_t        hdr;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            id;
    TxHdr_t        hdr;
    logic [DW-1:0] data;
  } obeat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccip_wr_arbiter_if #(.NUM_REQ(N), .HDR_W(HW), .DATA_W(DW)) bus ();

  ccip_wr_arbiter #(.NUM_REQ(N), .HDR_W(HW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     errors = 0;
  int     checks = 0;
  int     mdc    = 0;
  bit     exp_err_len;
  int     gcnt [N];
  beat_t  rq [N][$];
  obeat_t expq [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic TxHdr_t mk_hdr(ccip_reqtype_t t, logic [1:0] len, logic sop, logic [41:0] addr, logic [15:0] md);
    TxHdr_t h;
    h         = '0;
    h.reqtype = t;
    h.len     = ccip_len_t'(len);
    h.sop     = sop;
    h.addr    = addr;
    h.mdata   = md;
    return h;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  function automatic int pkt_len(TxHdr_t h);
    if (h.reqtype == CCIP_WRFENCE) return 1;
    case (h.len)
      CCIP_LEN_2: return 2;
      CCIP_LEN_4: return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic bit dropped(TxHdr_t h);
    return (h.reqtype != CCIP_WRFENCE) && (h.len == CCIP_LEN_ILLEGAL);
  endfunction

  task automatic drive(input int i, input TxHdr_t h, input logic [DW-1:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_hdr[i*HW +: HW]   = h;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.ch_full   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic add_pkt(input int id, input ccip_reqtype_t t, input logic [1:0] len);
    beat_t b;
    int    n;
    b.hdr = mk_hdr(t, len, 1'b1, 42'($urandom), 16'(mdc));
    n     = pkt_len(b.hdr);
    if (dropped(b.hdr)) exp_err_len = 1'b1;
    for (int k = 0; k < n; k++) begin
      b.hdr.sop   = (k == 0);
      b.hdr.addr  = 42'($urandom);
      b.hdr.mdata = 16'(mdc);
      b.data      = rnd_data();
      mdc++;
      rq[id].push_back(b);
    end
  endtask

  // Packet-level round robin over requesters that still have packets queued.
  task automatic model_build();
    int     pos [N];
    int     last;
    int     c;
    int     n;
    bit     any;
    obeat_t o;
    last = N - 1;
    for (int i = 0; i < N; i++) pos[i] = 0;
    do begin
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (last + k) % N;
        if (!any && pos[c] < rq[c].size()) begin
          any = 1'b1;
          n   = pkt_len(rq[c][pos[c]].hdr);
          if (!dropped(rq[c][pos[c]].hdr)) begin
            for (int b = 0; b < n; b++) begin
              o.id   = c;
              o.hdr  = rq[c][pos[c] + b].hdr;
              o.data = rq[c][pos[c] + b].data;
              expq.push_back(o);
            end
          end
          pos[c] += n;
          last    = c;
        end
      end
    end while (any);
  endtask

  task automatic run_queues(input int budget, input bit rand_full);
    logic [N-1:0] acc;
    int           cyc;
    int           left;
    bit           done;
    obeat_t       e;
    acc  = '0;
    cyc  = 0;
    done = 1'b0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) drive(i, rq[i][0].hdr, rq[i][0].data);
        else bus.req_valid[i] = 1'b0;
      end
      bus.ch_full = rand_full && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (bus.ch_wr_en) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("beat_grant", DW'(bus.grant_id), DW'(e.id));
          chk("beat_hdr", DW'(bus.ch_hdr), DW'(e.hdr));
          chk("beat_data", bus.ch_data, e.data);
          gcnt[bus.grant_id]++;
        end
      end
      if (bus.ch_full) chk("ready_under_full", DW'(bus.req_ready), 0);
      acc  = bus.req_valid & bus.req_ready;
      left = 0;
      for (int i = 0; i < N; i++) left += rq[i].size();
      done = (expq.size() == 0) && (left == 0);
      cyc++;
    end
    bus.req_valid = '0;
    bus.ch_full   = 1'b0;
    if (!done) chk("run_completed", 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          vt [5];
    TxHdr_t        h;
    TxHdr_t        bh [4];
    logic [DW-1:0] d;
    logic [DW-1:0] bd [4];
    int            o;

    vt[0] = '{0, CCIP_WRLINE_I, 2'b00, 1'b1, 42'h84000000, 1, 0, 0, 1};
    vt[1] = '{3, CCIP_WRLINE_I, 2'b10, 1'b1, 42'h00001230, 0, 1, 0, 1};
    vt[2] = '{1, CCIP_WRFENCE,  2'b11, 1'b1, 42'h00000000, 1, 0, 0, 1};
    vt[3] = '{2, CCIP_WRLINE_M, 2'b00, 1'b0, 42'h00ABCDE0, 1, 0, 1, 1};
    vt[4] = '{1, CCIP_WRLINE_I, 2'b01, 1'b1, 42'h00005540, 1, 0, 0, 0};

    bus.req_valid = '0;
    bus.req_hdr   = '0;
    bus.req_data  = '0;
    bus.ch_full   = 1'b0;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", DW'(bus.ch_wr_en), 0);
    chk("rst_hdr", DW'(bus.ch_hdr), 0);
    chk("rst_data", bus.ch_data, 0);
    chk("rst_grant", DW'(bus.grant_id), 0);
    chk("rst_err_len", DW'(bus.err_len), 0);
    chk("rst_err_sop", DW'(bus.err_sop), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-beat vector table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      @(posedge clk); #1;
      h = mk_hdr(vt[v].t, vt[v].len, vt[v].sop, vt[v].addr, 16'(v));
      d = rnd_data();
      drive(vt[v].id, h, d);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", v), DW'(bus.req_ready[vt[v].id]), 1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_wr_en", v), DW'(bus.ch_wr_en), DW'(vt[v].e_wr));
      if (vt[v].e_wr) begin
        chk($sformatf("vec%0d_hdr", v), DW'(bus.ch_hdr), DW'(h));
        chk($sformatf("vec%0d_data", v), bus.ch_data, d);
      end
      chk($sformatf("vec%0d_grant", v), DW'(bus.grant_id), DW'(vt[v].id));
      chk($sformatf("vec%0d_err_len", v), DW'(bus.err_len), DW'(vt[v].e_len));
      chk($sformatf("vec%0d_err_sop", v), DW'(bus.err_sop), DW'(vt[v].e_sop));
      o = (vt[v].id + 1) % N;
      drive(o, mk_hdr(CCIP_WRLINE_I, 2'b00, 1'b1, 42'h40, 16'hFFFF), '0);
      #1;
      chk($sformatf("vec%0d_other_ready", v), DW'(bus.req_ready[o]), DW'(vt[v].e_idle));
      bus.req_valid = '0;
    end

    // Contiguous packets: 4 beats of req0 then 2 of req1
    do_reset();
    exp_err_len = 1'b0;
    add_pkt(0, CCIP_WRLINE_I, 2'b11);
    add_pkt(1, CCIP_WRLINE_I, 2'b01);
    for (int b = 0; b < 4; b++) expq.push_back('{0, rq[0][b].hdr, rq[0][b].data});
    for (int b = 0; b < 2; b++) expq.push_back('{1, rq[1][b].hdr, rq[1][b].data});
    run_queues(100, 1'b0);
    chk("contig_cnt0", DW'(gcnt[0]), 4);
    chk("contig_cnt1", DW'(gcnt[1]), 2);

    // Round robin fairness with single beats
    do_reset();
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < N; i++) add_pkt(i, CCIP_WRLINE_I, 2'b00);
    for (int k = 0; k < 40; k++) expq.push_back('{k % N, rq[k % N][k / N].hdr, rq[k % N][k / N].data});
    run_queues(200, 1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("rr_cnt%0d", i), DW'(gcnt[i]), 10);

    // Backpressure in the middle of a 4-beat packet from req2
    do_reset();
    for (int b = 0; b < 4; b++) begin
      bh[b] = mk_hdr(CCIP_WRLINE_I, 2'b11, b == 0, 42'(32'h1000 + b), 16'(b));
      bd[b] = rnd_data();
    end
    @(posedge clk); #1;
    drive(2, bh[0], bd[0]);
    @(negedge clk);
    chk("bp_ready_b0", DW'(bus.req_ready), 4'b0100);
    @(posedge clk); #1;
    drive(2, bh[1], bd[1]);
    @(negedge clk);
    chk("bp_ready_b1", DW'(bus.req_ready), 4'b0100);
    chk("bp_wr_b0", DW'(bus.ch_wr_en), 1);
    @(posedge clk); #1;
    drive(2, bh[2], bd[2]);
    bus.ch_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_full%0d_ready", c), DW'(bus.req_ready), 0);
      chk($sformatf("bp_full%0d_wr_en", c), DW'(bus.ch_wr_en), DW'(c == 0));
      @(posedge clk); #1;
    end
    bus.ch_full = 1'b0;
    @(negedge clk);
    chk("bp_resume_ready", DW'(bus.req_ready), 4'b0100);
    chk("bp_resume_wr_en", DW'(bus.ch_wr_en), 0);
    @(posedge clk); #1;
    drive(2, bh[3], bd[3]);
    @(negedge clk);
    chk("bp_b2_wr_en", DW'(bus.ch_wr_en), 1);
    chk("bp_b2_data", bus.ch_data, bd[2]);
    chk("bp_b2_grant", DW'(bus.grant_id), 2);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_b3_wr_en", DW'(bus.ch_wr_en), 1);
    chk("bp_b3_data", bus.ch_data, bd[3]);
    chk("bp_b3_grant", DW'(bus.grant_id), 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_done_wr_en", DW'(bus.ch_wr_en), 0);

    // Reset in the middle of a burst from req1
    do_reset();
    @(posedge clk); #1;
    drive(3, mk_hdr(CCIP_WRLINE_I, 2'b10, 1'b1, 42'h80, 16'h33), '0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("mrst_pre_err_len", DW'(bus.err_len), 1);
    @(posedge clk); #1;
    drive(1, mk_hdr(CCIP_WRLINE_I, 2'b11, 1'b1, 42'h100, 16'h10), rnd_data());
    @(posedge clk); #1;
    drive(1, mk_hdr(CCIP_WRLINE_I, 2'b11, 1'b0, 42'h140, 16'h11), rnd_data());
    rst = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("mrst_wr_en", DW'(bus.ch_wr_en), 0);
    chk("mrst_hdr", DW'(bus.ch_hdr), 0);
    chk("mrst_data", bus.ch_data, 0);
    chk("mrst_grant", DW'(bus.grant_id), 0);
    chk("mrst_err_len", DW'(bus.err_len), 0);
    chk("mrst_err_sop", DW'(bus.err_sop), 0);
    @(posedge clk); #1;
    drive(0, mk_hdr(CCIP_WRLINE_I, 2'b00, 1'b1, 42'h200, 16'h20), rnd_data());
    drive(2, mk_hdr(CCIP_WRLINE_I, 2'b00, 1'b1, 42'h240, 16'h21), rnd_data());
    @(negedge clk);
    chk("mrst_next_ready", DW'(bus.req_ready), 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("mrst_next_wr_en", DW'(bus.ch_wr_en), 1);
    chk("mrst_next_grant", DW'(bus.grant_id), 0);

    // Randomized mixes against the packet-level model
    for (int r = 0; r < 3; r++) begin
      int t;
      do_reset();
      exp_err_len = 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int p = 0; p < int'($urandom_range(2, 6)); p++) begin
          t = $urandom_range(0, 9);
          if (t == 0)      add_pkt(i, CCIP_WRFENCE, 2'($urandom_range(0, 3)));
          else if (t == 1) add_pkt(i, CCIP_WRLINE_I, 2'b10);
          else if (t < 5)  add_pkt(i, CCIP_WRLINE_M, 2'b00);
          else if (t < 7)  add_pkt(i, CCIP_WRLINE_I, 2'b01);
          else             add_pkt(i, CCIP_WRLINE_I, 2'b11);
        end
      end
      model_build();
      run_queues(2000, 1'b1);
      @(negedge clk);
      chk($sformatf("rand%0d_err_len", r), DW'(bus.err_len), DW'(exp_err_len));
      chk($sformatf("rand%0d_err_sop", r), DW'(bus.err_sop), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
